// File: rtl/npu_conv_win_rd_seq.sv
// Read sequencer for the shared image/activation read port: walks every 3x3 tap of every
// output pixel and channel, issuing reads or pad bypasses, and flags beats aligned with read data.
`ifndef LOG2_ACT_ADDR_WIDTH
`define LOG2_ACT_ADDR_WIDTH 12
`endif

module npu_conv_win_rd_seq #(
  parameter int RD_LAT = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            src_rgb,
  input  logic [`LOG2_ACT_ADDR_WIDTH-1:0] base_addr,
  input  logic [6:0]                      img_w,
  input  logic [6:0]                      img_h,
  input  logic [5:0]                      num_ch,
  input  logic                            hold,
  output logic                            hw_rgb_mem_rd,
  output logic                            hw_act_mem_rd,
  output logic                            hw_act_mem_rd_bypass,
  output logic [`LOG2_ACT_ADDR_WIDTH-1:0] rd_addr,
  output logic                            beat_valid,
  output logic                            beat_last_ch,
  output logic                            beat_last_px,
  output logic                            busy,
  output logic                            done
);

  localparam int AW = `LOG2_ACT_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  // Latched layer configuration
  logic          src_rgb_reg;
  logic [6:0]    w_reg, h_reg;
  logic [5:0]    c_reg;
  logic [AW-1:0] plane_reg;

  // Loop counters and running address offsets
  logic [1:0]    kx_reg, kx_next, ky_reg, ky_next;
  logic [5:0]    ch_reg, ch_next;
  logic [6:0]    ox_reg, ox_next, oy_reg, oy_next;
  logic [AW-1:0] tap_addr_reg, tap_addr_next;
  logic [AW-1:0] chan_addr_reg, chan_addr_next;
  logic [AW-1:0] pix_addr_reg, pix_addr_next;
  logic [AW-1:0] addr_hold_reg;

  logic [RD_LAT-1:0] vld_sr_reg, vld_sr_next;
  logic [RD_LAT-1:0] lch_sr_reg, lch_sr_next;
  logic [RD_LAT-1:0] lpx_sr_reg, lpx_sr_next;

  logic          dims_ok, issue, pad, tap_last, ch_last, px_last, accept;
  logic [AW-1:0] w_ext;
  logic [13:0]   plane_full;

  assign dims_ok    = (img_w != 7'd0) && (img_h != 7'd0) && (num_ch != 6'd0);
  assign accept     = (state_reg == IDLE) && start;
  assign plane_full = 14'(img_w) * 14'(img_h);
  assign w_ext      = AW'(w_reg);

  assign issue = (state_reg == RUN) && !hold;

  // A tap is padding when it falls one row/column outside the image
  assign pad = ((ky_reg == 2'd0) && (oy_reg == 7'd0))
            || ((ky_reg == 2'd2) && (oy_reg == h_reg - 7'd1))
            || ((kx_reg == 2'd0) && (ox_reg == 7'd0))
            || ((kx_reg == 2'd2) && (ox_reg == w_reg - 7'd1));

  assign tap_last = (kx_reg == 2'd2) && (ky_reg == 2'd2);
  assign ch_last  = tap_last && (ch_reg == c_reg - 6'd1);
  assign px_last  = ch_last && (ox_reg == w_reg - 7'd1) && (oy_reg == h_reg - 7'd1);

  assign hw_rgb_mem_rd        = issue && !pad && src_rgb_reg;
  assign hw_act_mem_rd        = issue && !pad && !src_rgb_reg;
  assign hw_act_mem_rd_bypass = issue && pad;
  assign rd_addr              = (issue && !pad) ? tap_addr_reg : addr_hold_reg;

  assign beat_valid   = vld_sr_reg[RD_LAT-1];
  assign beat_last_ch = lch_sr_reg[RD_LAT-1];
  assign beat_last_px = lpx_sr_reg[RD_LAT-1];
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = dims_ok ? RUN : DONE;
      RUN:     if (issue && px_last) state_next = DRAIN;
      DRAIN:   if (vld_sr_reg[RD_LAT-1] && lpx_sr_reg[RD_LAT-1]) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tap_addr tracks base + (c*H + oy+ky-1)*W + ox+kx-1 modulo 2^AW, pads included
  always_comb begin
    kx_next        = kx_reg;
    ky_next        = ky_reg;
    ch_next        = ch_reg;
    ox_next        = ox_reg;
    oy_next        = oy_reg;
    tap_addr_next  = tap_addr_reg;
    chan_addr_next = chan_addr_reg;
    pix_addr_next  = pix_addr_reg;
    if (accept) begin
      kx_next        = 2'd0;
      ky_next        = 2'd0;
      ch_next        = 6'd0;
      ox_next        = 7'd0;
      oy_next        = 7'd0;
      pix_addr_next  = base_addr;
      chan_addr_next = base_addr;
      tap_addr_next  = base_addr - AW'(img_w) - AW'(1);
    end else if (issue) begin
      if (kx_reg != 2'd2) begin
        kx_next       = kx_reg + 2'd1;
        tap_addr_next = tap_addr_reg + AW'(1);
      end else if (ky_reg != 2'd2) begin
        kx_next       = 2'd0;
        ky_next       = ky_reg + 2'd1;
        tap_addr_next = tap_addr_reg + w_ext - AW'(2);
      end else begin
        kx_next = 2'd0;
        ky_next = 2'd0;
        if (ch_reg != c_reg - 6'd1) begin
          ch_next        = ch_reg + 6'd1;
          chan_addr_next = chan_addr_reg + plane_reg;
          tap_addr_next  = chan_addr_reg + plane_reg - w_ext - AW'(1);
        end else begin
          // Row-major pixel order makes the channel-0 center simply advance by one
          ch_next        = 6'd0;
          pix_addr_next  = pix_addr_reg + AW'(1);
          chan_addr_next = pix_addr_reg + AW'(1);
          tap_addr_next  = pix_addr_reg - w_ext;
          if (ox_reg != w_reg - 7'd1) begin
            ox_next = ox_reg + 7'd1;
          end else begin
            ox_next = 7'd0;
            oy_next = oy_reg + 7'd1;
          end
        end
      end
    end
  end

  always_comb begin
    vld_sr_next = RD_LAT'({vld_sr_reg, issue});
    lch_sr_next = RD_LAT'({lch_sr_reg, issue && ch_last});
    lpx_sr_next = RD_LAT'({lpx_sr_reg, issue && px_last});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_rgb_reg   <= 1'b0;
      w_reg         <= '0;
      h_reg         <= '0;
      c_reg         <= '0;
      plane_reg     <= '0;
      kx_reg        <= '0;
      ky_reg        <= '0;
      ch_reg        <= '0;
      ox_reg        <= '0;
      oy_reg        <= '0;
      tap_addr_reg  <= '0;
      chan_addr_reg <= '0;
      pix_addr_reg  <= '0;
      addr_hold_reg <= '0;
      vld_sr_reg    <= '0;
      lch_sr_reg    <= '0;
      lpx_sr_reg    <= '0;
    end else begin
      if (accept) begin
        src_rgb_reg <= src_rgb;
        w_reg       <= img_w;
        h_reg       <= img_h;
        c_reg       <= num_ch;
        plane_reg   <= AW'(plane_full);
      end
      if (issue && !pad) addr_hold_reg <= tap_addr_reg;
      kx_reg        <= kx_next;
      ky_reg        <= ky_next;
      ch_reg        <= ch_next;
      ox_reg        <= ox_next;
      oy_reg        <= oy_next;
      tap_addr_reg  <= tap_addr_next;
      chan_addr_reg <= chan_addr_next;
      pix_addr_reg  <= pix_addr_next;
      vld_sr_reg    <= vld_sr_next;
      lch_sr_reg    <= lch_sr_next;
      lpx_sr_reg    <= lpx_sr_next;
    end
  end

endmodule

// File: tb/tb_npu_conv_win_rd_seq.sv
// Directed bench for npu_conv_win_rd_seq: runs whole layers, logs every cycle, then
// checks tap kinds, addresses, beat flags and done/busy timing against hand-computed values.
`ifndef LOG2_ACT_ADDR_WIDTH
`define LOG2_ACT_ADDR_WIDTH 12
`endif

module tb_npu_conv_win_rd_seq;

  localparam int AW = `LOG2_ACT_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          resetn, start, src_rgb, hold;
  logic [AW-1:0] base_addr;
  logic [6:0]    img_w, img_h;
  logic [5:0]    num_ch;
  logic          hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass;
  logic [AW-1:0] rd_addr;
  logic          beat_valid, beat_last_ch, beat_last_px, busy, done;

  always #5 clk = ~clk;

  npu_conv_win_rd_seq #(.RD_LAT(2)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .start                (start),
    .src_rgb              (src_rgb),
    .base_addr            (base_addr),
    .img_w                (img_w),
    .img_h                (img_h),
    .num_ch               (num_ch),
    .hold                 (hold),
    .hw_rgb_mem_rd        (hw_rgb_mem_rd),
    .hw_act_mem_rd        (hw_act_mem_rd),
    .hw_act_mem_rd_bypass (hw_act_mem_rd_bypass),
    .rd_addr              (rd_addr),
    .beat_valid           (beat_valid),
    .beat_last_ch         (beat_last_ch),
    .beat_last_px         (beat_last_px),
    .busy                 (busy),
    .done                 (done)
  );

  int tests = 0;
  int fails = 0;

  // Per-run log; kind: 0 pad, 1 act read, 2 rgb read
  int            n_beats, n_valid, n_rgb, n_act, first_valid, done_cnt, done_cyc;
  int            first_busy, last_busy, onehot_err, held_iss;
  logic [1:0]    b_kind [0:1023];
  logic [AW-1:0] b_addr [0:1023];
  logic          v_last_ch [0:1023];
  logic          v_last_px [0:1023];
  logic          vcyc [0:255];

  // Pixel (0,0) of a 2x2 single-channel image at base 0x10
  int exp_kind [9] = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
  int exp_addr [9] = '{0, 0, 0, 0, 'h10, 'h11, 0, 'h12, 'h13};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic rgb, input logic [AW-1:0] base, input logic [6:0] w,
                         input logic [6:0] h, input logic [5:0] c, input int hold_s,
                         input int hold_l, input int restart_at, input int abort_at,
                         input int max_cyc);
    int sum;
    n_beats = 0; n_valid = 0; n_rgb = 0; n_act = 0; first_valid = -1;
    done_cnt = 0; done_cyc = -1; first_busy = -1; last_busy = -1;
    onehot_err = 0; held_iss = 0;
    for (int i = 0; i < 256; i++) vcyc[i] = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; src_rgb = rgb; base_addr = base; img_w = w; img_h = h; num_ch = c;
    @(posedge clk); #1;  // cycle 0 edge: config sampled
    start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      hold = (k >= hold_s) && (k < hold_s + hold_l);
      start = (k == restart_at);
      if (k == restart_at) img_h = 7'd0;
      @(negedge clk);
      sum = int'(hw_rgb_mem_rd) + int'(hw_act_mem_rd) + int'(hw_act_mem_rd_bypass);
      if (sum > 1) onehot_err++;
      if (sum != 0) begin
        if (hold) held_iss++;
        b_kind[n_beats] = hw_rgb_mem_rd ? 2'd2 : (hw_act_mem_rd ? 2'd1 : 2'd0);
        b_addr[n_beats] = rd_addr;
        if (hw_rgb_mem_rd) n_rgb++;
        if (hw_act_mem_rd) n_act++;
        n_beats++;
      end
      if (beat_valid) begin
        if (first_valid < 0) first_valid = k;
        vcyc[k] = 1'b1;
        v_last_ch[n_valid] = beat_last_ch;
        v_last_px[n_valid] = beat_last_px;
        n_valid++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (busy) begin
        if (first_busy < 0) first_busy = k;
        last_busy = k;
      end
      if (k == abort_at) break;
      @(posedge clk); #1;
    end
    hold = 1'b0; start = 1'b0;
    $display("[TB] run %0dx%0dx%0d base=0x%0h: beats=%0d valids=%0d first_valid=%0d done@%0d",
             w, h, c, base, n_beats, n_valid, first_valid, done_cyc);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; src_rgb = 1'b0; hold = 1'b0;
    base_addr = '0; img_w = '0; img_h = '0; num_ch = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass, beat_valid,
                     beat_last_ch, beat_last_px, busy, done}, 8'h00);
    chk("rst_addr", rd_addr, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_outs", {hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass, beat_valid,
                      beat_last_ch, beat_last_px, busy, done}, 8'h00);

    // 2x2x1 act, with an ignored zero-dim start mid-run
    run_seq(1'b0, AW'('h10), 7'd2, 7'd2, 6'd1, 0, 0, 10, 0, 45);
    chk("t1_beats", n_beats, 36);
    chk("t1_valids", n_valid, 36);
    chk("t1_first_valid", first_valid, 3);
    chk("t1_done_cyc", done_cyc, 39);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_first_busy", first_busy, 1);
    chk("t1_last_busy", last_busy, 39);
    chk("t1_onehot", onehot_err, 0);
    chk("t1_rgb", n_rgb, 0);
    for (int b = 0; b < 9; b++) begin
      chk($sformatf("t1_kind%0d", b), b_kind[b], exp_kind[b]);
      if (exp_kind[b] != 0) chk($sformatf("t1_addr%0d", b), b_addr[b], exp_addr[b]);
    end
    chk("t1_kind28", b_kind[27], 1);
    chk("t1_addr28", b_addr[27], 'h10);
    chk("t1_kind36", b_kind[35], 0);
    for (int v = 0; v < 36; v++) begin
      chk($sformatf("t1_last_ch%0d", v + 1), v_last_ch[v], (v % 9 == 8));
      chk($sformatf("t1_last_px%0d", v + 1), v_last_px[v], (v == 35));
    end

    // 1x1x2 rgb: only center taps read
    run_seq(1'b1, AW'('h20), 7'd1, 7'd1, 6'd2, 0, 0, 0, 0, 30);
    chk("t2_beats", n_beats, 18);
    chk("t2_rgb", n_rgb, 2);
    chk("t2_act", n_act, 0);
    chk("t2_kind5", b_kind[4], 2);
    chk("t2_addr5", b_addr[4], 'h20);
    chk("t2_kind14", b_kind[13], 2);
    chk("t2_addr14", b_addr[13], 'h21);
    chk("t2_done_cyc", done_cyc, 21);

    // Hold for cycles 4..8 (beats 4.. delayed by 5)
    run_seq(1'b0, AW'('h10), 7'd2, 7'd2, 6'd1, 4, 5, 0, 0, 50);
    chk("t3_beats", n_beats, 36);
    chk("t3_held_iss", held_iss, 0);
    chk("t3_v4", vcyc[4], 1);
    chk("t3_v5", vcyc[5], 1);
    chk("t3_v6", vcyc[6], 0);
    chk("t3_v10", vcyc[10], 0);
    chk("t3_v11", vcyc[11], 1);
    chk("t3_done_cyc", done_cyc, 44);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_addr4", b_addr[4], 'h10);

    // Zero height
    run_seq(1'b0, AW'('h10), 7'd2, 7'd0, 6'd1, 0, 0, 0, 0, 6);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_first_busy", first_busy, 1);
    chk("t4_last_busy", last_busy, 1);
    chk("t4_beats", n_beats, 0);
    chk("t4_valids", n_valid, 0);

    // Address wrap at the top of the address space
    run_seq(1'b0, AW'((1 << AW) - 2), 7'd2, 7'd2, 6'd1, 0, 0, 0, 0, 45);
    chk("t5_addr5", b_addr[4], (1 << AW) - 2);
    chk("t5_addr14", b_addr[13], (1 << AW) - 1);
    chk("t5_kind23", b_kind[22], 1);
    chk("t5_addr23", b_addr[22], 0);
    chk("t5_kind32", b_kind[31], 1);
    chk("t5_addr32", b_addr[31], 1);

    // Abort with reset at beat 10, then a full run
    run_seq(1'b0, AW'('h10), 7'd2, 7'd2, 6'd1, 0, 0, 0, 10, 45);
    chk("t6_beats_pre", n_beats, 10);
    chk("t6_done_pre", done_cnt, 0);
    resetn = 1'b0;
    #1;
    chk("t6_rst_outs", {hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass, beat_valid,
                        beat_last_ch, beat_last_px, busy, done}, 8'h00);
    chk("t6_rst_addr", rd_addr, 0);
    @(posedge clk); #1;
    chk("t6_rst_outs2", {hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass, beat_valid,
                         beat_last_ch, beat_last_px, busy, done}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    run_seq(1'b0, AW'('h10), 7'd2, 7'd2, 6'd1, 0, 0, 0, 0, 45);
    chk("t6_beats", n_beats, 36);
    chk("t6_done_cyc", done_cyc, 39);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_addr5", b_addr[4], 'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/npu_conv_win_rd_seq.md
# npu_conv_win_rd_seq

Read sequencer for the shared image/activation read port of the NPU. For one convolution layer it walks every output pixel, input channel and 3x3 tap, and drives the RGB/activation read strobes, read address and pad-bypass flag that feed the image/activation memory read mux. It also produces a beat-valid strobe and tap/group markers aligned with the registered muxed read data, so the MAC array can consume taps directly. Zero padding of 1 is applied at image borders through the bypass path, so no memory read is issued for a pad tap.

## Interface
Parameters:
- RD_LAT, 2, cycles from read strobe to valid muxed data; covers memory read plus mux register.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; config is sampled on this cycle; ignored while busy.
- src_rgb  in  1  1 = read RGB memory, 0 = read activation memory.
- base_addr  in  `LOG2_ACT_ADDR_WIDTH  base address of channel 0, row 0, column 0.
- img_w  in  7  input width, 0..64.
- img_h  in  7  input height, 0..64.
- num_ch  in  6  input channels, 0..32.
- hold  in  1  freezes issue; already-issued beats still complete.
- hw_rgb_mem_rd  out  1  RGB read strobe.
- hw_act_mem_rd  out  1  activation read strobe.
- hw_act_mem_rd_bypass  out  1  pad tap; muxed data is forced to 0.
- rd_addr  out  `LOG2_ACT_ADDR_WIDTH  read address.
- beat_valid  out  1  muxed read data is valid this cycle.
- beat_last_ch  out  1  with beat_valid: last tap of the last channel of an output pixel.
- beat_last_px  out  1  with beat_valid: final beat of the layer.
- busy  out  1  sequence in progress.
- done  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start when img_w, img_h and num_ch are all nonzero. Config is latched on the start cycle.
- IDLE → DONE on start when any dimension is zero. No strobes are issued.
- Loop order is outermost to innermost: oy 0..H-1, ox 0..W-1, c 0..C-1, ky 0..2, kx 0..2. This gives 9·C·W·H beats.
- Each beat computes iy = oy+ky-1 and ix = ox+kx-1.
- Pad tap (iy or ix outside 0..H-1 / 0..W-1): hw_act_mem_rd_bypass = 1, both read strobes = 0, rd_addr holds its previous value.
- Non-pad tap: assert hw_rgb_mem_rd if src_rgb, else hw_act_mem_rd.
  - rd_addr = base_addr + (c·H + iy)·W + ix, truncated modulo 2^`LOG2_ACT_ADDR_WIDTH.
  - Build the address from incremental running offsets. No multiplier on the per-beat path.
- Exactly one of {rgb_rd, act_rd, bypass} is high on every issued beat. All three are low when no beat is issued.
- hold = 1 in RUN: no beat is issued, loop counters freeze, all three strobes are 0. Beats already issued still emerge RD_LAT later. The consumer must absorb up to RD_LAT beats after raising hold.
- After the final beat is issued: RUN → DRAIN. Stay in DRAIN until that beat's beat_valid has been output, then → DONE.
- DONE: done = 1 for one cycle, then → IDLE.
- beat_valid, beat_last_ch and beat_last_px are the issue-time flags delayed by an RD_LAT-deep shift register.
- busy = 1 in RUN, DRAIN and DONE.

## Timing
- Reset values: every output is 0 and the state is IDLE. The internal shift register and counters are cleared.
- Reset asserted mid-sequence aborts immediately. No done pulse is generated.
- Start sampled at cycle 0:
  - First beat issued at cycle 1 (if hold = 0).
  - Its beat_valid is at cycle 1+RD_LAT.
  - busy rises at cycle 1.
- With no hold, beats issue back-to-back, one per cycle.
- Last beat issued at cycle N (hold-free N = 9·C·W·H) → last beat_valid at N+RD_LAT → done at N+RD_LAT+1 → busy low at N+RD_LAT+2.
- Zero-dimension start: done at cycle 1, busy high at cycle 1 only, no beat_valid.
- start while busy, including in the DONE cycle, is ignored.
- hold is sampled in the same cycle as the issue decision. Deasserting hold resumes issue in that same cycle.

## Test plan
- W=H=2, C=1, base=0x10, act src, no hold → 36 beats.
  - Pixel (0,0) tap sequence: pad, pad, pad, pad, act 0x10, act 0x11, pad, act 0x12, act 0x13.
  - beat_last_ch on beats 9, 18, 27, 36. beat_last_px on beat 36.
  - First beat_valid at cycle 3, done at cycle 39.
- W=H=1, C=2, base=0x20, src_rgb=1 → 18 beats. Only the center taps read: rgb 0x20, then 0x21. All other taps bypass.
- hold high for 5 cycles starting at beat 4 of the W=H=2 case → strobes low for those 5 cycles, beat_valid continues for 2 cycles then gaps, done at cycle 44.
- img_h=0 → done at cycle 1, no strobes, no beat_valid. A second start during the first run is ignored (exactly one done).
- base = 2^`LOG2_ACT_ADDR_WIDTH − 2, W=H=2, C=1 → center-tap addresses wrap to 0x0 and 0x1.
- resetn low at beat 10 → all outputs 0 next edge. A new start after release runs a full 36 beats.
